// File: rtl/arb_pkg.sv
// Shared types and default sizing for the register write arbiter family.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        COMMIT,
        COOL
    } arb_state_t;

    localparam int ARB_NUM_REQ_DEF = 4;
    localparam int ARB_DATA_W_DEF  = 4;
    localparam int ARB_HOLD_DEF    = 2;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/module_reg_arbiter.sv
// Round-robin single-writer arbiter for a shared register: grant, commit+ack, then cooldown.
module module_reg_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ     = ARB_NUM_REQ_DEF,
    parameter int DATA_W      = ARB_DATA_W_DEF,
    parameter int HOLD_CYCLES = ARB_HOLD_DEF
) (
    input  logic                        in_arb_clk,
    input  logic                        in_arb_rst,
    input  logic                        in_arb_en,
    input  logic [NUM_REQ-1:0]          in_arb_req,
    input  logic [NUM_REQ*DATA_W-1:0]   in_arb_data,
    output logic [NUM_REQ-1:0]          out_arb_gnt,
    output logic [NUM_REQ-1:0]          out_arb_ack,
    output logic [$clog2(NUM_REQ)-1:0]  out_arb_owner,
    output logic [DATA_W-1:0]           out_arb_reg,
    output logic                        out_arb_busy
);

    localparam int IDX_W     = $clog2(NUM_REQ);
    localparam int CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0]   sh_reg_q, sh_reg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [DATA_W-1:0]   owner_data;
    logic [NUM_REQ-1:0]  owner_onehot;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (in_arb_req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign owner_data   = in_arb_data[int'(owner_q)*DATA_W +: DATA_W];
    assign owner_onehot = NUM_REQ'(1) << owner_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        gnt_d    = gnt_q;
        ack_d    = ack_q;
        sh_reg_d = sh_reg_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_arb_en && pick_valid) begin
                    owner_d = pick_idx;
                    gnt_d   = pick_gnt;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                gnt_d = '0;
                // A withdrawn request abandons the grant without touching the pointer.
                if (in_arb_req[owner_q]) begin
                    sh_reg_d = owner_data;
                    ack_d    = owner_onehot;
                    ptr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d  = COMMIT;
                end else begin
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                ack_d = '0;
                if (HOLD_CYCLES > 0) begin
                    cnt_d   = CNT_W'(HOLD_LOAD);
                    state_d = COOL;
                end else begin
                    state_d = IDLE;
                end
            end
            COOL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge in_arb_clk or negedge in_arb_rst) begin
        if (!in_arb_rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            // NOTE: the shared register is a plain flop, so it is reset like the control state.
            sh_reg_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            sh_reg_q <= sh_reg_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_arb_gnt   = gnt_q;
    assign out_arb_ack   = ack_q;
    assign out_arb_owner = owner_q;
    assign out_arb_reg   = sh_reg_q;
    assign out_arb_busy  = (state_q != IDLE);

endmodule
